// File: rtl/swnet.sv
// swnet: store-word-to-network transmitter.
// Packs an SWNET op {waddr, wdata} into one packet and pushes it into the NI write FIFO.
// A 2-entry skid buffer (head/tail) absorbs NI back-pressure so the core stalls only when
// both entries are occupied. Packets leave strictly in acceptance order.
module swnet #(
    parameter  int unsigned ADDRSIZE = 5,
    parameter  int unsigned MSB_SLOT = 5,
    localparam int unsigned DSIZE    = 1 << MSB_SLOT,
    localparam int unsigned RSIZE    = 1 << (MSB_SLOT - 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             core_write_en,
    input  logic [RSIZE-1:0] core_waddr,
    input  logic [RSIZE-1:0] core_wdata,
    output logic             core_wfull,
    output logic             core_idle,
    output logic             ni_write_en,
    output logic [DSIZE-1:0] ni_wdata,
    input  logic             ni_wfull,
    output logic [RSIZE-1:0] tx_count
);

    // ADDRSIZE only mirrors the NI FIFO depth; reject nonsensical parameter sets at elaboration.
    if (ADDRSIZE < 1 || MSB_SLOT < 2) begin : g_param_check
        $error("swnet: ADDRSIZE must be >= 1 and MSB_SLOT must be >= 2");
    end

    // Occupancy of the skid buffer; head is valid whenever state is not StEmpty.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           state_q;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] tail_q;
    logic [RSIZE-1:0] tx_count_q;

    logic             accept;
    logic             send;
    logic [DSIZE-1:0] new_pkt;

    // Handshakes and the incoming packet; all decodes come from registered state.
    always_comb begin
        core_wfull  = (state_q == StTwo);
        core_idle   = (state_q == StEmpty);
        ni_write_en = (state_q != StEmpty) & ~ni_wfull;
        ni_wdata    = head_q;
        tx_count    = tx_count_q;
        accept      = core_write_en & ~core_wfull;
        send        = ni_write_en;
        new_pkt     = {core_waddr, core_wdata};
    end

    // Occupancy FSM with head/tail entries; a reset drops everything buffered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_q  <= new_pkt;
                        state_q <= StOne;
                    end
                end
                StOne: begin
                    if (accept && send) begin
                        // Head leaves this edge, so the new packet becomes head directly.
                        head_q <= new_pkt;
                    end else if (accept) begin
                        tail_q  <= new_pkt;
                        state_q <= StTwo;
                    end else if (send) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    // core_wfull is high here, so no accept can coincide with this move.
                    if (send) begin
                        head_q  <= tail_q;
                        state_q <= StOne;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    // Delivered-packet counter; wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_count_q <= '0;
        end else if (send) begin
            tx_count_q <= tx_count_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_swnet.sv
// Directed self-checking bench for swnet.
module tb_swnet;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_write_en = 1'b0;
    logic [15:0] core_waddr = '0;
    logic [15:0] core_wdata = '0;
    logic        core_wfull;
    logic        core_idle;
    logic        ni_write_en;
    logic [31:0] ni_wdata;
    logic        ni_wfull = 1'b0;
    logic [15:0] tx_count;

    int n_checks = 0;
    int n_fail   = 0;

    swnet #(
        .ADDRSIZE(5),
        .MSB_SLOT(5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_write_en(core_write_en),
        .core_waddr   (core_waddr),
        .core_wdata   (core_wdata),
        .core_wfull   (core_wfull),
        .core_idle    (core_idle),
        .ni_write_en  (ni_write_en),
        .ni_wdata     (ni_wdata),
        .ni_wfull     (ni_wfull),
        .tx_count     (tx_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset         = 1'b0;
        core_write_en = 1'b0;
        ni_wfull      = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        core_write_en = 1'b1;
        core_waddr    = 16'h0000;
        core_wdata    = 16'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ni_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_ni_write_en got %b want 0", ni_write_en); end
        n_checks++; if (core_idle !== 1'b1) begin n_fail++; $display("FAIL reset_core_idle got %b want 1", core_idle); end
        n_checks++; if (core_wfull !== 1'b0) begin n_fail++; $display("FAIL reset_core_wfull got %b want 0", core_wfull); end
        n_checks++; if (tx_count !== 16'h0000) begin n_fail++; $display("FAIL reset_tx_count got %h want 0000", tx_count); end
        n_checks++; if (ni_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_ni_wdata got %h want 00000000", ni_wdata); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        core_write_en = 1'b0;
        @(negedge clk);
        n_checks++; if (ni_write_en !== 1'b1) begin n_fail++; $display("FAIL release_ni_write_en got %b want 1", ni_write_en); end
        n_checks++; if (ni_wdata !== 32'h00000001) begin n_fail++; $display("FAIL release_ni_wdata got %h want 00000001", ni_wdata); end
        n_checks++; if (core_idle !== 1'b0) begin n_fail++; $display("FAIL release_core_idle got %b want 0", core_idle); end
    endtask

    task automatic test_single();
        do_reset();
        core_waddr    = 16'h0012;
        core_wdata    = 16'hBEEF;
        core_write_en = 1'b1;
        @(negedge clk);
        n_checks++; if (ni_write_en !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got %b want 0", ni_write_en); end
        @(posedge clk);
        #1;
        core_write_en = 1'b0;
        @(negedge clk);
        n_checks++; if (ni_write_en !== 1'b1) begin n_fail++; $display("FAIL single_ni_write_en got %b want 1", ni_write_en); end
        n_checks++; if (ni_wdata !== 32'h0012BEEF) begin n_fail++; $display("FAIL single_ni_wdata got %h want 0012BEEF", ni_wdata); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL single_tx_count got %0d want 1", tx_count); end
        n_checks++; if (core_idle !== 1'b1) begin n_fail++; $display("FAIL single_core_idle got %b want 1", core_idle); end
        n_checks++; if (ni_write_en !== 1'b0) begin n_fail++; $display("FAIL single_done_ni_write_en got %b want 0", ni_write_en); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        ni_wfull      = 1'b1;
        core_write_en = 1'b1;
        core_waddr    = 16'h0001;
        core_wdata    = 16'hAAAA;
        @(posedge clk);
        #1;
        core_waddr = 16'h0002;
        core_wdata = 16'hBBBB;
        @(negedge clk);
        n_checks++; if (core_wfull !== 1'b0) begin n_fail++; $display("FAIL bp_one_wfull got %b want 0", core_wfull); end
        @(posedge clk);
        #1;
        core_waddr = 16'h0003;
        core_wdata = 16'hCCCC;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (core_wfull !== 1'b1) begin n_fail++; $display("FAIL bp_two_wfull got %b want 1", core_wfull); end
            n_checks++; if (ni_write_en !== 1'b0) begin n_fail++; $display("FAIL bp_held_ni_write_en got %b want 0", ni_write_en); end
            n_checks++; if (ni_wdata !== 32'h0001AAAA) begin n_fail++; $display("FAIL bp_held_head got %h want 0001AAAA", ni_wdata); end
            @(posedge clk);
            #1;
        end
        ni_wfull = 1'b0;
        @(negedge clk);
        n_checks++; if (ni_write_en !== 1'b1 || ni_wdata !== 32'h0001AAAA) begin n_fail++; $display("FAIL bp_send_a got en=%b data=%h want en=1 data=0001AAAA", ni_write_en, ni_wdata); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (core_wfull !== 1'b0) begin n_fail++; $display("FAIL bp_after_a_wfull got %b want 0", core_wfull); end
        n_checks++; if (ni_write_en !== 1'b1 || ni_wdata !== 32'h0002BBBB) begin n_fail++; $display("FAIL bp_send_b got en=%b data=%h want en=1 data=0002BBBB", ni_write_en, ni_wdata); end
        @(posedge clk);
        #1;
        core_write_en = 1'b0;
        @(negedge clk);
        n_checks++; if (ni_write_en !== 1'b1 || ni_wdata !== 32'h0003CCCC) begin n_fail++; $display("FAIL bp_send_c got en=%b data=%h want en=1 data=0003CCCC", ni_write_en, ni_wdata); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx_count !== 16'd3) begin n_fail++; $display("FAIL bp_tx_count got %0d want 3", tx_count); end
        n_checks++; if (core_idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle got %b want 1", core_idle); end
    endtask

    task automatic test_streaming();
        logic [31:0] pkt [8];
        int          high_cycles = 0;
        do_reset();
        for (int i = 0; i < 8; i++) pkt[i] = {16'h2000 + 16'(i), 16'h5A00 + 16'(i * 3)};
        for (int i = 0; i < 10; i++) begin
            core_write_en = (i < 8);
            if (i < 8) {core_waddr, core_wdata} = pkt[i];
            @(negedge clk);
            n_checks++; if (core_wfull !== 1'b0) begin n_fail++; $display("FAIL stream_wfull_%0d got %b want 0", i, core_wfull); end
            if (i >= 1 && i <= 8) begin
                n_checks++; if (ni_write_en !== 1'b1 || ni_wdata !== pkt[i-1]) begin n_fail++; $display("FAIL stream_pkt_%0d got en=%b data=%h want en=1 data=%h", i - 1, ni_write_en, ni_wdata, pkt[i-1]); end
            end else begin
                n_checks++; if (ni_write_en !== 1'b0) begin n_fail++; $display("FAIL stream_idle_%0d got %b want 0", i, ni_write_en); end
            end
            if (ni_write_en === 1'b1) high_cycles++;
            @(posedge clk);
            #1;
        end
        n_checks++; if (high_cycles != 8) begin n_fail++; $display("FAIL stream_high_cycles got %0d want 8", high_cycles); end
        n_checks++; if (tx_count !== 16'd8) begin n_fail++; $display("FAIL stream_tx_count got %0d want 8", tx_count); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] q [$];
        int          issued = 0;
        int          sent   = 0;
        int          cyc    = 0;
        bit          acc;
        do_reset();
        ni_wfull      = 1'b1;
        core_write_en = 1'b1;
        core_waddr    = 16'h0100;
        core_wdata    = 16'hC000;
        @(posedge clk);
        #1;
        q.push_back(32'h0100C000);
        issued = 1;
        while ((issued < 13 || q.size() != 0) && cyc < 100) begin
            core_write_en = (issued < 13);
            core_waddr    = 16'h0100 + 16'(issued);
            core_wdata    = 16'hC000 + 16'(issued);
            ni_wfull      = ~ni_wfull;
            @(negedge clk);
            n_checks++; if (core_wfull !== (q.size() == 2)) begin n_fail++; $display("FAIL sim_wfull_c%0d got %b want %b", cyc, core_wfull, q.size() == 2); end
            n_checks++; if (core_idle !== (q.size() == 0)) begin n_fail++; $display("FAIL sim_idle_c%0d got %b want %b", cyc, core_idle, q.size() == 0); end
            n_checks++; if (ni_write_en !== (q.size() != 0 && !ni_wfull)) begin n_fail++; $display("FAIL sim_en_c%0d got %b want %b", cyc, ni_write_en, q.size() != 0 && !ni_wfull); end
            acc = core_write_en && (core_wfull === 1'b0);
            if (ni_write_en === 1'b1 && !ni_wfull && q.size() != 0) begin
                n_checks++; if (ni_wdata !== q[0]) begin n_fail++; $display("FAIL sim_order_%0d got %h want %h", sent, ni_wdata, q[0]); end
                void'(q.pop_front());
                sent++;
            end
            if (acc) begin
                q.push_back({core_waddr, core_wdata});
                issued++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        core_write_en = 1'b0;
        ni_wfull      = 1'b0;
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL sim_timeout got %0d pending want 0", q.size()); end
        n_checks++; if (sent != 13) begin n_fail++; $display("FAIL sim_sent got %0d want 13", sent); end
        @(negedge clk);
        n_checks++; if (tx_count !== 16'd13) begin n_fail++; $display("FAIL sim_tx_count got %0d want 13", tx_count); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        core_waddr    = 16'h7777;
        core_wdata    = 16'h1234;
        core_write_en = 1'b1;
        // 65536 accepts back to back; the last one is still buffered after 65535 sends.
        repeat (65536) @(posedge clk);
        #1;
        core_write_en = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got %h want FFFF", tx_count); end
        n_checks++; if (ni_write_en !== 1'b1) begin n_fail++; $display("FAIL wrap_pending got %b want 1", ni_write_en); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (tx_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_post got %h want 0000", tx_count); end
        // Fill to two entries, then reset asynchronously mid-cycle.
        #4;
        ni_wfull      = 1'b1;
        core_write_en = 1'b1;
        core_waddr    = 16'h0EAD;
        core_wdata    = 16'h0001;
        @(posedge clk);
        #1;
        core_wdata = 16'h0002;
        @(posedge clk);
        #1;
        core_write_en = 1'b0;
        @(negedge clk);
        n_checks++; if (core_wfull !== 1'b1) begin n_fail++; $display("FAIL mid_two_wfull got %b want 1", core_wfull); end
        ni_wfull = 1'b0;
        #1;
        n_checks++; if (ni_write_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_en got %b want 1", ni_write_en); end
        reset = 1'b0;
        #1;
        n_checks++; if (ni_write_en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_en got %b want 0", ni_write_en); end
        n_checks++; if (core_idle !== 1'b1 || core_wfull !== 1'b0) begin n_fail++; $display("FAIL mid_reset_state got idle=%b full=%b want idle=1 full=0", core_idle, core_wfull); end
        n_checks++; if (ni_wdata !== 32'h0 || tx_count !== 16'h0) begin n_fail++; $display("FAIL mid_reset_data got wdata=%h cnt=%h want 0/0", ni_wdata, tx_count); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (ni_write_en !== 1'b0 || core_idle !== 1'b1) begin n_fail++; $display("FAIL mid_after_release got en=%b idle=%b want en=0 idle=1", ni_write_en, core_idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_pressure();
        test_streaming();
        test_simultaneous();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
